rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writers.
- Requester A is the in-order pipeline writeback and normally wins; requester B is the multi-cycle unit (mul/div, late loads).
- A starvation guard guarantees B forward progress.
- Drives a registered write port (we/addr/data) straight into the register file; optionally tracks pending destinations for issue stalls.

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_arbiter_scoreboard.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter slice.
package rf_wb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-destination bits for B-bound ops, with two combinational source lookups.
module rf_wb_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_valid_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_valid_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pend_q, pend_d;

  // Clear is applied first so a same-cycle set of the same address wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_valid_i) pend_d[clr_addr_i] = 1'b0;
    if (set_valid_i && (set_addr_i != '0)) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign rs_busy_o = pend_q[rs_addr_i];
  assign rt_busy_o = pend_q[rt_addr_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-writer arbiter for the register-file write port: A has priority, B is forced
// through after STARVE_MAX denied cycles. Define RF_WB_SCOREBOARD_EN for pending-dest tracking.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o
);

  arb_state_e                state_q, state_d;
  logic [STARVE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                      a_ready, b_ready, a_hs, b_hs, hs;
  req_id_e                   grant;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      rf_we_q;
  logic [ADDR_W-1:0]         rf_addr_q;
  logic [DATA_W-1:0]         rf_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      PRIO_A: begin
        a_ready = a_valid_i;
        b_ready = b_valid_i & ~a_valid_i;
        if (!b_valid_i || b_ready) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d >= STARVE_CNT_W'(STARVE_MAX)) state_d = FORCE_B;
        end
      end
      FORCE_B: begin
        b_ready = b_valid_i;
        // Leaves after one cycle whether B was granted or has dropped its request.
        cnt_d   = '0;
        state_d = PRIO_A;
      end
      default: state_d = PRIO_A;
    endcase
    if (rst_i) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PRIO_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_ready_o = a_ready;
  assign b_ready_o = b_ready;
  assign a_hs      = a_valid_i & a_ready;
  assign b_hs      = b_valid_i & b_ready;
  assign hs        = a_hs | b_hs;
  assign grant     = b_hs ? REQ_B : REQ_A;
  assign wr_addr   = (grant == REQ_B) ? b_addr_i : a_addr_i;
  assign wr_data   = (grant == REQ_B) ? b_data_i : a_data_i;

  // Register $0 is hardwired: the handshake completes but no write is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= hs && (wr_addr != '0);
      if (hs) begin
        rf_addr_q <= wr_addr;
        rf_data_q <= wr_data;
      end
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;

`ifdef RF_WB_SCOREBOARD_EN
  rf_wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_valid_i (iss_valid_i),
    .set_addr_i  (iss_addr_i),
    .clr_valid_i (b_hs),
    .clr_addr_i  (b_addr_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .rs_busy_o   (rs_busy_o),
    .rt_busy_o   (rt_busy_o)
  );
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid_i, iss_addr_i, rs_addr_i, rt_addr_i};
  assign rs_busy_o  = 1'b0;
  assign rt_busy_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (default parameters); scoreboard expectations
// follow RF_WB_SCOREBOARD_EN.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

`ifdef RF_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, iss_valid;
  logic [ADDR_W-1:0] a_addr, b_addr, iss_addr, rs_addr, rt_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, rf_we, rs_busy, rt_busy;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a_valid_i   (a_valid),
    .a_addr_i    (a_addr),
    .a_data_i    (a_data),
    .a_ready_o   (a_ready),
    .b_valid_i   (b_valid),
    .b_addr_i    (b_addr),
    .b_data_i    (b_data),
    .b_ready_o   (b_ready),
    .rf_we_o     (rf_we),
    .rf_addr_o   (rf_addr),
    .rf_data_o   (rf_data),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .rs_addr_i   (rs_addr),
    .rt_addr_i   (rt_addr),
    .rs_busy_o   (rs_busy),
    .rt_busy_o   (rt_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; b_valid = 0; iss_valid = 0;
    a_addr = '0; b_addr = '0; iss_addr = '0; rs_addr = '0; rt_addr = '0;
    a_data = '0; b_data = '0;
    step(); step();
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    a_valid = 1; b_valid = 1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    a_valid = 0; b_valid = 0;
    rst = 1'b0;
    step();

    // Single A write to r8
    a_valid = 1; a_addr = 8; a_data = 32'h1234;
    #1;
    chk("a_ready", a_ready, 1);
    chk("a_only_b_ready", b_ready, 0);
    step();
    a_valid = 0;
    chk("a_we", rf_we, 1);
    chk("a_addr", rf_addr, 8);
    chk("a_data", rf_data, 32'h1234);
    step();
    chk("a_we_drop", rf_we, 0);

    // Both valid: B starves three cycles then is forced
    a_valid = 1; a_addr = 3; a_data = 32'hA3;
    b_valid = 1; b_addr = 4; b_data = 32'hB4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("starve_a_ready", a_ready, 1);
      chk("starve_b_ready", b_ready, 0);
      step();
      chk("starve_rf_addr", rf_addr, 3);
    end
    #1;
    chk("force_b_ready", b_ready, 1);
    chk("force_a_ready", a_ready, 0);
    step();
    chk("force_we", rf_we, 1);
    chk("force_addr", rf_addr, 4);
    chk("force_data", rf_data, 32'hB4);
    #1;
    chk("after_a_ready", a_ready, 1);
    chk("after_b_ready", b_ready, 0);
    step();
    chk("after_addr", rf_addr, 3);
    a_valid = 0; b_valid = 0;
    step();

    // Write to r0: accepted but no write enable
    a_valid = 1; a_addr = 0; a_data = 32'hFFFF;
    #1;
    chk("r0_a_ready", a_ready, 1);
    step();
    a_valid = 0;
    chk("r0_we", rf_we, 0);
    chk("r0_data", rf_data, 32'hFFFF);

    // Async reset right after a B handshake to r9
    b_valid = 1; b_addr = 9; b_data = 32'h99;
    #1;
    chk("b9_ready", b_ready, 1);
    step();
    b_valid = 0;
    chk("b9_we", rf_we, 1);
    chk("b9_addr", rf_addr, 9);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", rf_we, 0);
    chk("midrst_addr", rf_addr, 0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_we0", rf_we, 0);
    step();
    chk("postrst_we1", rf_we, 0);

    // Pending destination tracking
    iss_valid = 1; iss_addr = 12; rs_addr = 12; rt_addr = 13;
    step();
    iss_valid = 0;
    chk("sb_set_rs", rs_busy, SB);
    chk("sb_set_rt", rt_busy, 0);
    b_valid = 1; b_addr = 12; b_data = 32'hC;
    #1;
    chk("sb_b_ready", b_ready, 1);
    chk("sb_hold_busy", rs_busy, SB);
    step();
    b_valid = 0;
    chk("sb_clr", rs_busy, 0);
    iss_valid = 1; iss_addr = 12;
    step();
    chk("sb_reset_busy", rs_busy, SB);
    b_valid = 1; b_addr = 12;
    step();
    iss_valid = 0; b_valid = 0;
    chk("sb_set_wins", rs_busy, SB);
    iss_valid = 1; iss_addr = 0; rt_addr = 0;
    step();
    iss_valid = 0;
    chk("sb_r0_ignored", rt_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finish");
    $fatal(1);
  end

endmodule
